mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the single-ported unified instruction/data memory of the multicycle MIPS core. It shares the memory between two requesters, the CPU datapath (fetch/load/store) and the program loader (boot/debug writes and reads). It serialises their transactions into one memory access at a time, with a fixed memory read latency. The CPU control FSM waits on `cpu_gnt` before leaving any memory-touching state.

## Interface
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, data width in bits.
- `RD_LAT`, 1, memory read latency in cycles, legal range 1..4.

Ports:
- `cclk`  in  1  clock; all logic on the rising edge.
- `rstb`  in  1  reset; synchronous, active-low.
- `cpu_req`  in  1  CPU transaction request; held until `cpu_gnt`.
- `cpu_we`  in  1  CPU write (1) or read (0).
- `cpu_addr`  in  ADDR_W  CPU byte address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_gnt`  out  1  one-cycle pulse when the CPU transaction completes.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`: same as the CPU set, for the loader.
- `rd_data`  out  DATA_W  read data, shared by both requesters; valid with the owner's `*_gnt` on reads.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write strobe.
- `mem_re`  out  1  memory read strobe.
- `mem_rdata`  in  DATA_W  memory read data, valid `RD_LAT` cycles after the `mem_re` cycle.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If no request, stay in IDLE.
  - If any `*_req`, the picker selects the owner.
  - Latch owner, `we`, `addr` and `wdata` into registers, then go to ISSUE.
- ISSUE
  - Drive `mem_addr` and `mem_wdata` from the latched registers.
  - Assert `mem_we` if the latched `we` is 1, otherwise `mem_re`, for exactly this one cycle.
  - Write: pulse the owner's `gnt` in this cycle, then go to IDLE.
  - Read: load `cnt = RD_LAT-1`, then go to WAIT.
- WAIT
  - Decrement `cnt` each cycle.
  - When `cnt == 0`, capture `mem_rdata` into `rd_data` and go to RESP.
- RESP: pulse the owner's `gnt`; `rd_data` is held. Go to IDLE.
- `rd_data` keeps its last value until the next read capture.
- The losing requester's `req` stays pending. It is served in the next IDLE cycle, per the arbitration rule.
- Requesters must not change `req`, `we`, `addr` or `wdata` before their `gnt`.
  - The transaction is latched at IDLE exit.
  - Later input changes do not affect the transaction in flight.
- A requester whose `req` is still high the cycle after its `gnt` starts a new transaction. The CPU FSM therefore deasserts `req` on `gnt`.
- `mem_addr` and `mem_wdata` hold the latched values outside ISSUE. Memory ignores them, because the strobes are 0.

## Timing
- Reset values
  - State: IDLE.
  - All outputs 0: `cpu_gnt`, `ldr_gnt`, `mem_we`, `mem_re`, `mem_addr`, `mem_wdata`, `rd_data`.
  - Round-robin pointer (`last_owner`): LDR.
- Write latency: `req` high in cycle 0, IDLE sees it, giving `mem_we` and `gnt` in cycle 1.
- Read latency, with `req` in cycle 0:
  - `mem_re` in cycle 1.
  - `gnt` plus valid `rd_data` in cycle `2+RD_LAT` (cycle 3 for `RD_LAT=1`).
- Minimum 1 IDLE cycle between transactions; no back-to-back issue.
- Simultaneous requests in IDLE are resolved by the picker; exactly one owner.
- Reset mid-transaction
  - Aborts the transaction; no `gnt` is issued.
  - A strobe asserted in the reset cycle is dropped at that edge.
- All outputs are registered; no combinational path from `*_req` to any output.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the requester other than `last_owner` wins.
  - `last_owner` updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, loader over CPU.
  - `last_owner` is not implemented.

## Structure
- Package `mem_arb_pkg`:
  - state encodings `ST_IDLE=2'd0`, `ST_ISSUE=2'd1`, `ST_WAIT=2'd2`, `ST_RESP=2'd3`;
  - owner ids `OWN_CPU=1'b0`, `OWN_LDR=1'b1`.
- Sub-module `mem_arb_pick`: combinational picker.
  - Inputs: `cpu_req`, `ldr_req`, `last_owner`.
  - Outputs: `winner`, `any_req`.
  - Holds the macro-dependent logic.

## Test plan
- CPU read alone, `RD_LAT=1`, `cpu_addr=0x40`, `mem_rdata=0xDEADBEEF` → `mem_re` in cycle 1, `cpu_gnt` and `rd_data=0xDEADBEEF` in cycle 3, `ldr_gnt` stays 0.
- Loader write alone, addr `0x100`, data `0x12345678` → `mem_we=1`, `mem_addr=0x100`, `mem_wdata=0x12345678` and `ldr_gnt` all in cycle 1.
- Both requesters assert writes in the same cycle and hold:
  - with `MEM_ARB_RR_EN`: CPU served first, loader next;
  - without the macro: loader first, CPU next.
- Both requesters hold `req` continuously, with the macro → grants alternate CPU, LDR, CPU, LDR.
- `RD_LAT=4` read → `gnt` in cycle 6; `mem_addr` is stable in cycles 1..6 even if `cpu_addr` changes in cycle 2.
- `rstb=0` in cycle 2 (WAIT) of a read → no `gnt` ever; all outputs 0 the next cycle; a fresh request after reset completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings and owner ids for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational owner picker; MEM_ARB_RR_EN selects round-robin, else loader-first priority
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last_owner,
    output logic winner,
    output logic any_req
);

    assign any_req = cpu_req | ldr_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not own the port last time wins.
    always_comb begin
        winner = OWN_CPU;
        if (cpu_req && ldr_req) begin
            winner = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (ldr_req) begin
            winner = OWN_LDR;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        winner = OWN_CPU;
        if (ldr_req) begin
            winner = OWN_LDR;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory sequencer shared by CPU and loader; MEM_ARB_RR_EN enables round-robin
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              own_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_nxt;
    logic              last_owner;
    logic              winner;
    logic              any_req;

    logic              latch;
    logic              cap;
    logic              we_nxt;
    logic              re_nxt;
    logic              cpu_gnt_nxt;
    logic              ldr_gnt_nxt;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    mem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .ldr_req    (ldr_req),
        .last_owner (last_owner),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign sel_we    = (winner == OWN_LDR) ? ldr_we    : cpu_we;
    assign sel_addr  = (winner == OWN_LDR) ? ldr_addr  : cpu_addr;
    assign sel_wdata = (winner == OWN_LDR) ? ldr_wdata : cpu_wdata;

    // The latched transaction registers double as the memory address/data outputs.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state plus the next value of every registered output, so strobes and
    // grants appear in the cycle named by the state they belong to.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_q;
        latch       = 1'b0;
        cap         = 1'b0;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;
        cpu_gnt_nxt = 1'b0;
        ldr_gnt_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    latch     = 1'b1;
                    state_nxt = ST_ISSUE;
                    we_nxt    = sel_we;
                    re_nxt    = ~sel_we;
                    if (sel_we) begin
                        cpu_gnt_nxt = (winner == OWN_CPU);
                        ldr_gnt_nxt = (winner == OWN_LDR);
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    cap         = 1'b1;
                    state_nxt   = ST_RESP;
                    cpu_gnt_nxt = (own_q == OWN_CPU);
                    ldr_gnt_nxt = (own_q == OWN_LDR);
                end else begin
                    cnt_nxt = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            own_q   <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 2'd0;
            rd_data <= '0;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            cpu_gnt <= 1'b0;
            ldr_gnt <= 1'b0;
        end else begin
            if (latch) begin
                own_q   <= winner;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (cap) begin
                rd_data <= mem_rdata;
            end
            cnt_q   <= cnt_nxt;
            mem_we  <= we_nxt;
            mem_re  <= re_nxt;
            cpu_gnt <= cpu_gnt_nxt;
            ldr_gnt <= ldr_gnt_nxt;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            last_owner <= OWN_LDR;
        end else if (cpu_gnt_nxt) begin
            last_owner <= OWN_CPU;
        end else if (ldr_gnt_nxt) begin
            last_owner <= OWN_LDR;
        end
    end
`else
    assign last_owner = OWN_LDR;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (both MEM_ARB_RR_EN builds)
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        cclk = 1'b0;
    logic        rstb;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic        cpu_gnt, ldr_gnt, mem_we, mem_re;
    logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;

    logic        c4_req, c4_we, c4_gnt, l4_gnt, mwe4, mre4;
    logic [31:0] c4_addr, c4_wdata, rd4, ma4, mwd4, mrd4;
    logic        l4_req, l4_we;
    logic [31:0] l4_addr, l4_wdata;

    always #5 cclk = ~cclk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
        .cclk(cclk), .rstb(rstb),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
        .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(4)) dut4 (
        .cclk(cclk), .rstb(rstb),
        .cpu_req(c4_req), .cpu_we(c4_we), .cpu_addr(c4_addr), .cpu_wdata(c4_wdata), .cpu_gnt(c4_gnt),
        .ldr_req(l4_req), .ldr_we(l4_we), .ldr_addr(l4_addr), .ldr_wdata(l4_wdata), .ldr_gnt(l4_gnt),
        .rd_data(rd4), .mem_addr(ma4), .mem_wdata(mwd4), .mem_we(mwe4), .mem_re(mre4),
        .mem_rdata(mrd4)
    );

    // Behavioural memory shared by both instances; idle pipeline slots carry junk.
    logic [31:0] dev_mem [0:255];
    logic [31:0] pipe1;
    logic [31:0] pipe4 [0:3];

    always @(posedge cclk) begin
        if (mem_we) dev_mem[mem_addr[9:2]] <= mem_wdata;
        pipe1    <= mem_re ? dev_mem[mem_addr[9:2]] : $urandom;
        pipe4[0] <= mre4 ? dev_mem[ma4[9:2]] : $urandom;
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end
    assign mem_rdata = pipe1;
    assign mrd4      = pipe4[3];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          free_at = 0;
    int          t_issue, t_gnt;
    int          n_model_gnt = 0;
    int          n_obs_gnt = 0;
    bit          act = 1'b0;
    bit          m_own, m_we, m_last;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0, e_rd = '0;
    logic [31:0] ref_mem [0:255];
    bit          gq[$];
    bit          exp_two[2];
    bit          exp_cont[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the transaction-level model: start a transaction when free,
    // advance, then compare every output with what the schedule predicts.
    task automatic step();
        bit rst_now;
        bit w;
        rst_now = !rstb;
        if (rstb && cyc >= free_at && (cpu_req || ldr_req)) begin
            if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
                w = (m_last == OWN_CPU) ? OWN_LDR : OWN_CPU;
`else
                w = OWN_LDR;
`endif
            end else begin
                w = ldr_req ? OWN_LDR : OWN_CPU;
            end
            act     = 1'b1;
            m_own   = w;
            m_last  = w;
            m_we    = (w == OWN_LDR) ? ldr_we : cpu_we;
            m_addr  = (w == OWN_LDR) ? ldr_addr : cpu_addr;
            m_wdata = (w == OWN_LDR) ? ldr_wdata : cpu_wdata;
            t_issue = cyc + 1;
            t_gnt   = m_we ? cyc + 1 : cyc + 3;
            free_at = t_gnt + 1;
            if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
            else      m_rd = ref_mem[m_addr[9:2]];
        end
        @(posedge cclk);
        #1;
        cyc++;
        if (rst_now) begin
            act = 1'b0; m_addr = '0; m_wdata = '0; e_rd = '0;
            m_last = OWN_LDR; free_at = cyc;
        end
        if (act && cyc == t_gnt && !m_we) e_rd = m_rd;
        chk("cpu_gnt",   32'(cpu_gnt), 32'(act && cyc == t_gnt && m_own == OWN_CPU));
        chk("ldr_gnt",   32'(ldr_gnt), 32'(act && cyc == t_gnt && m_own == OWN_LDR));
        chk("mem_we",    32'(mem_we),  32'(act && cyc == t_issue && m_we));
        chk("mem_re",    32'(mem_re),  32'(act && cyc == t_issue && !m_we));
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("rd_data",   rd_data,   e_rd);
        if (cpu_gnt) begin gq.push_back(OWN_CPU); n_obs_gnt++; end
        if (ldr_gnt) begin gq.push_back(OWN_LDR); n_obs_gnt++; end
        if (act && cyc >= t_gnt) begin act = 1'b0; n_model_gnt++; end
    endtask

    task automatic drain(input int maxc);
        bit done;
        done = 1'b0;
        for (int n = 0; n < maxc && !done; n++) begin
            if (cpu_gnt) cpu_req = 1'b0;
            if (ldr_gnt) ldr_req = 1'b0;
            if (!cpu_req && !ldr_req && !act && cyc >= free_at) done = 1'b1;
            else step();
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
    endtask

    task automatic ldr_write(input logic [31:0] a, input logic [31:0] d);
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = a; ldr_wdata = d;
        drain(20);
    endtask

    task automatic rand_txn(output logic req, output logic we, output logic [31:0] a, output logic [31:0] d);
        req = 1'b1;
        we  = 1'($urandom_range(1));
        a   = 32'h200 + 32'(4 * $urandom_range(15));
        d   = $urandom;
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_two = '{OWN_CPU, OWN_LDR};
        exp_cont = '{OWN_CPU, OWN_LDR, OWN_CPU, OWN_LDR};
`else
        exp_two = '{OWN_LDR, OWN_CPU};
        exp_cont = '{OWN_LDR, OWN_LDR, OWN_LDR, OWN_LDR};
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        m_last = OWN_LDR;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        c4_req = 0; c4_we = 0; c4_addr = 0; c4_wdata = 0;
        l4_req = 0; l4_we = 0; l4_addr = 0; l4_wdata = 0;
        rstb = 1'b0;
        step();
        step();
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        rstb = 1'b1;

        ldr_write(32'h40, 32'hDEADBEEF);

        // Loader write alone: strobe, address, data and grant in cycle 1.
        do_reset();
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h100; ldr_wdata = 32'h12345678;
        step();
        chk("lw_mem_we", 32'(mem_we), 32'd1);
        chk("lw_mem_addr", mem_addr, 32'h100);
        chk("lw_mem_wdata", mem_wdata, 32'h12345678);
        chk("lw_ldr_gnt", 32'(ldr_gnt), 32'd1);
        drain(20);

        // CPU read alone: mem_re in cycle 1, grant and data in cycle 3.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        step();
        chk("cr_mem_re_c1", 32'(mem_re), 32'd1);
        step();
        chk("cr_gnt_c2", 32'(cpu_gnt), 32'd0);
        step();
        chk("cr_gnt_c3", 32'(cpu_gnt), 32'd1);
        chk("cr_rd_data_c3", rd_data, 32'hDEADBEEF);
        chk("cr_ldr_gnt_c3", 32'(ldr_gnt), 32'd0);
        drain(20);

        // Simultaneous writes: the picker decides the order.
        do_reset();
        gq.delete();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h200; cpu_wdata = 32'hA5A5_0001;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h204; ldr_wdata = 32'h5A5A_0002;
        drain(30);
        chk("tie_count", 32'(gq.size()), 32'd2);
        if (gq.size() == 2) begin
            chk("tie_first", 32'(gq[0]), 32'(exp_two[0]));
            chk("tie_second", 32'(gq[1]), 32'(exp_two[1]));
        end

        // Both hold continuously.
        do_reset();
        gq.delete();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h208; cpu_wdata = 32'h1111_2222;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20C; ldr_wdata = 32'h3333_4444;
        for (int n = 0; n < 40 && gq.size() < 4; n++) step();
        cpu_req = 0; ldr_req = 0;
        drain(20);
        chk("cont_count_ge4", 32'(gq.size() >= 4), 32'd1);
        if (gq.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), 32'(gq[i]), 32'(exp_cont[i]));
        end

        // Reset while the read is in WAIT: no grant, all outputs cleared.
        do_reset();
        gq.delete();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        step();
        step();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        cpu_req = 0;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        for (int n = 0; n < 5; n++) step();
        chk("rst_no_gnt", 32'(gq.size()), 32'd0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        drain(20);
        chk("rst_fresh_read", rd_data, 32'h12345678);

        // Randomized traffic over a written address window.
        for (int i = 0; i < 16; i++) ldr_write(32'h200 + 32'(4 * i), $urandom);
        n_model_gnt = 0;
        n_obs_gnt = 0;
        for (int n = 0; n < 400; n++) begin
            if (cpu_gnt) begin
                if ($urandom_range(1) == 1) rand_txn(cpu_req, cpu_we, cpu_addr, cpu_wdata);
                else cpu_req = 0;
            end else if (!cpu_req && $urandom_range(2) == 0) begin
                rand_txn(cpu_req, cpu_we, cpu_addr, cpu_wdata);
            end
            if (ldr_gnt) begin
                if ($urandom_range(1) == 1) rand_txn(ldr_req, ldr_we, ldr_addr, ldr_wdata);
                else ldr_req = 0;
            end else if (!ldr_req && $urandom_range(2) == 0) begin
                rand_txn(ldr_req, ldr_we, ldr_addr, ldr_wdata);
            end
            step();
        end
        drain(40);
        chk("rand_grant_count", 32'(n_obs_gnt), 32'(n_model_gnt));

        // RD_LAT=4 instance: grant in cycle 6, address stable despite input change.
        c4_req = 1; c4_we = 0; c4_addr = 32'h40;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k <= 6) chk($sformatf("lat4_addr_c%0d", k), ma4, 32'h40);
            chk($sformatf("lat4_re_c%0d", k), 32'(mre4), 32'(k == 1));
            chk($sformatf("lat4_gnt_c%0d", k), 32'(c4_gnt), 32'(k == 6));
            if (k == 6) chk("lat4_rd_data", rd4, 32'hDEADBEEF);
            if (k == 2) c4_addr = 32'h80;
            if (k == 6) c4_req = 0;
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
